// File: rtl/reg_wb_ctrl_if.sv
// Bus bundle for the register-writeback controller: issue claim, hazard check,
// two writeback requesters, register-file write port and status.
interface reg_wb_ctrl_if;
    logic        iss_valid;
    logic [3:0]  iss_dest;
    logic        iss_ready;

    logic [3:0]  chk_a;
    logic [3:0]  chk_b;
    logic [3:0]  chk_m;
    logic [3:0]  chk_p;
    logic        hazard;

    logic        alu_valid;
    logic [3:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;

    logic        mem_valid;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;

    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;

    logic [15:0] busy;
    logic [4:0]  pend_cnt;
    logic        wb_err;

    modport master (
        output iss_valid, iss_dest, chk_a, chk_b, chk_m, chk_p,
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        input  iss_ready, hazard, alu_ready, mem_ready,
        input  wr_en, wr_addr, wr_data, busy, pend_cnt, wb_err
    );

    modport slave (
        input  iss_valid, iss_dest, chk_a, chk_b, chk_m, chk_p,
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        output iss_ready, hazard, alu_ready, mem_ready,
        output wr_en, wr_addr, wr_data, busy, pend_cnt, wb_err
    );
endinterface

// File: rtl/reg_wb_ctrl.sv
// Scoreboard of pending register writes plus a round-robin arbiter that
// funnels ALU/MEM writebacks into a single registered register-file write port.
module reg_wb_ctrl (
    input  logic          clk,
    input  logic          rst_n,
    reg_wb_ctrl_if.slave  bus
);

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_MEM = 1'b1
    } prio_e;

    prio_e       prio_q, prio_d;
    logic [15:0] busy_q, busy_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        wr_en_q, wr_en_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic        claim_ok;
    logic        claim_acc;
    logic        alu_gnt;
    logic        mem_gnt;
    logic        wb_acc;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;

    always_comb begin
        claim_ok  = (bus.iss_dest == 4'd0) || !busy_q[bus.iss_dest];
        claim_acc = bus.iss_valid && claim_ok;
    end

    // A lone requester always wins; the pointer only matters on contention.
    always_comb begin
        alu_gnt = bus.alu_valid && (!bus.mem_valid || (prio_q == PRIO_ALU));
        mem_gnt = bus.mem_valid && (!bus.alu_valid || (prio_q == PRIO_MEM));
        wb_acc  = alu_gnt || mem_gnt;
        wb_addr = alu_gnt ? bus.alu_addr : bus.mem_addr;
        wb_data = alu_gnt ? bus.alu_data : bus.mem_data;
    end

    always_comb begin
        prio_d    = prio_q;
        busy_d    = busy_q;
        cnt_d     = '0;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (alu_gnt) begin
            prio_d = PRIO_MEM;
        end else if (mem_gnt) begin
            prio_d = PRIO_ALU;
        end

        if (wb_acc) begin
            wr_en_d   = (wb_addr != 4'd0);
            wr_addr_d = wb_addr;
            wr_data_d = wb_data;
            if ((wb_addr != 4'd0) && !busy_q[wb_addr]) begin
                err_d = 1'b1;
            end
        end

        // Clear lags the write by a cycle so hazard covers the write cycle itself.
        if (wr_en_q) begin
            busy_d[wr_addr_q] = 1'b0;
        end
        if (claim_acc && (bus.iss_dest != 4'd0)) begin
            busy_d[bus.iss_dest] = 1'b1;
        end
        busy_d[0] = 1'b0;

        for (int unsigned i = 0; i < 16; i++) begin
            cnt_d = cnt_d + {4'b0000, busy_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q    <= PRIO_ALU;
            busy_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            prio_q    <= prio_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        bus.iss_ready = claim_ok;
        bus.hazard    = busy_q[bus.chk_a] || busy_q[bus.chk_b] ||
                        busy_q[bus.chk_m] || busy_q[bus.chk_p];
        bus.alu_ready = alu_gnt;
        bus.mem_ready = mem_gnt;
        bus.wr_en     = wr_en_q;
        bus.wr_addr   = wr_addr_q;
        bus.wr_data   = wr_data_q;
        bus.busy      = busy_q;
        bus.pend_cnt  = cnt_q;
        bus.wb_err    = err_q;
    end

    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n) !(alu_gnt && mem_gnt));
    a_r0_free:   assert property (@(posedge clk) disable iff (!rst_n) !busy_q[0]);

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed vector table for reg_wb_ctrl plus hand-written reset-mid-operation sequence.
module tb_reg_wb_ctrl;

    logic clk;
    logic rst_n;
    reg_wb_ctrl_if bus ();

    reg_wb_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned rb;
        int unsigned iv, id;
        int unsigned av, aa, ad;
        int unsigned mv, ma, md;
        int unsigned ca, cb, cm, cp;
        int unsigned irdy, ardy, mrdy, haz;
        int unsigned wen, wa, wd;
        int unsigned busy, cnt, err;
    } vec_t;

    vec_t tbl [25];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic idle();
        bus.iss_valid = 1'b0; bus.iss_dest = '0;
        bus.chk_a = '0; bus.chk_b = '0; bus.chk_m = '0; bus.chk_p = '0;
        bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply(input int idx, input vec_t v);
        if (v.rb != 0) do_reset();
        @(negedge clk);
        bus.iss_valid = v.iv[0];  bus.iss_dest = v.id[3:0];
        bus.alu_valid = v.av[0];  bus.alu_addr = v.aa[3:0]; bus.alu_data = v.ad;
        bus.mem_valid = v.mv[0];  bus.mem_addr = v.ma[3:0]; bus.mem_data = v.md;
        bus.chk_a = v.ca[3:0]; bus.chk_b = v.cb[3:0]; bus.chk_m = v.cm[3:0]; bus.chk_p = v.cp[3:0];
        #1;
        chk($sformatf("v%0d.iss_ready", idx), 32'(bus.iss_ready), v.irdy);
        chk($sformatf("v%0d.alu_ready", idx), 32'(bus.alu_ready), v.ardy);
        chk($sformatf("v%0d.mem_ready", idx), 32'(bus.mem_ready), v.mrdy);
        chk($sformatf("v%0d.hazard", idx),    32'(bus.hazard),    v.haz);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d.wr_en", idx), 32'(bus.wr_en), v.wen);
        if (v.wen != 0) begin
            chk($sformatf("v%0d.wr_addr", idx), 32'(bus.wr_addr), v.wa);
            chk($sformatf("v%0d.wr_data", idx), bus.wr_data, v.wd);
        end
        chk($sformatf("v%0d.busy", idx),     32'(bus.busy),     v.busy);
        chk($sformatf("v%0d.pend_cnt", idx), 32'(bus.pend_cnt), v.cnt);
        chk($sformatf("v%0d.wb_err", idx),   32'(bus.wb_err),   v.err);
    endtask

    task automatic claim(input logic [3:0] r);
        @(negedge clk);
        idle();
        bus.iss_valid = 1'b1; bus.iss_dest = r;
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rb iv id  av aa ad            mv ma md     ca cb cm cp  ir ar mr hz  we wa wd             busy    cnt err
        tbl[0]  = '{0, 1,1,   0,0,0,            0,0,0,       0,0,0,0,    1,0,0,0,    0,0,0,            'h0002, 1,0};
        tbl[1]  = '{0, 1,2,   0,0,0,            0,0,0,       0,0,0,0,    1,0,0,0,    0,0,0,            'h0006, 2,0};
        tbl[2]  = '{0, 1,3,   0,0,0,            0,0,0,       0,0,0,0,    1,0,0,0,    0,0,0,            'h000E, 3,0};
        tbl[3]  = '{0, 1,4,   0,0,0,            0,0,0,       1,0,0,0,    1,0,0,1,    0,0,0,            'h001E, 4,0};
        tbl[4]  = '{0, 0,0,   1,1,'hA1,         1,2,'hB2,    2,0,0,0,    1,1,0,1,    1,1,'hA1,         'h001E, 4,0};
        tbl[5]  = '{0, 0,0,   1,3,'hA3,         1,2,'hB2,    0,1,0,0,    1,0,1,1,    1,2,'hB2,         'h001C, 3,0};
        tbl[6]  = '{0, 0,0,   1,3,'hA3,         1,4,'hB4,    0,0,3,0,    1,1,0,1,    1,3,'hA3,         'h0018, 2,0};
        tbl[7]  = '{0, 0,0,   1,3,'hA3,         1,4,'hB4,    0,0,0,4,    1,0,1,1,    1,4,'hB4,         'h0010, 1,0};
        tbl[8]  = '{0, 0,0,   0,0,0,            0,0,0,       0,0,0,0,    1,0,0,0,    0,0,0,            'h0000, 0,0};
        tbl[9]  = '{0, 1,5,   0,0,0,            0,0,0,       5,0,0,0,    1,0,0,0,    0,0,0,            'h0020, 1,0};
        tbl[10] = '{0, 0,0,   1,5,'hDEADBEEF,   0,0,0,       5,0,0,0,    1,1,0,1,    1,5,'hDEADBEEF,   'h0020, 1,0};
        tbl[11] = '{0, 0,0,   0,0,0,            0,0,0,       0,5,0,0,    1,0,0,1,    0,0,0,            'h0000, 0,0};
        tbl[12] = '{0, 0,0,   0,0,0,            0,0,0,       5,5,5,5,    1,0,0,0,    0,0,0,            'h0000, 0,0};
        tbl[13] = '{0, 1,10,  0,0,0,            0,0,0,       0,0,0,0,    1,0,0,0,    0,0,0,            'h0400, 1,0};
        tbl[14] = '{0, 0,0,   0,0,0,            1,10,1,      0,0,0,10,   1,0,1,1,    1,10,1,           'h0400, 1,0};
        tbl[15] = '{0, 0,0,   0,0,0,            1,10,2,      0,0,0,10,   1,0,1,1,    1,10,2,           'h0000, 0,0};
        tbl[16] = '{0, 0,0,   0,0,0,            1,10,3,      0,0,0,10,   1,0,1,0,    1,10,3,           'h0000, 0,1};
        tbl[17] = '{0, 0,0,   0,0,0,            0,0,0,       0,0,0,0,    1,0,0,0,    0,0,0,            'h0000, 0,1};
        tbl[18] = '{1, 1,7,   0,0,0,            0,0,0,       0,0,0,0,    1,0,0,0,    0,0,0,            'h0080, 1,0};
        tbl[19] = '{0, 1,7,   0,0,0,            0,0,0,       0,0,0,7,    0,0,0,1,    0,0,0,            'h0080, 1,0};
        tbl[20] = '{0, 1,0,   0,0,0,            0,0,0,       0,0,0,7,    1,0,0,1,    0,0,0,            'h0080, 1,0};
        tbl[21] = '{0, 0,0,   0,0,0,            1,9,'h99,    9,0,0,0,    1,0,1,0,    1,9,'h99,         'h0080, 1,1};
        tbl[22] = '{0, 0,0,   1,0,'h1234,       0,0,0,       0,0,0,0,    1,1,0,0,    0,0,0,            'h0080, 1,1};
        tbl[23] = '{0, 0,0,   1,7,'h77,         0,0,0,       7,0,0,0,    1,1,0,1,    1,7,'h77,         'h0080, 1,1};
        tbl[24] = '{0, 1,8,   0,0,0,            0,0,0,       7,0,0,0,    1,0,0,1,    0,0,0,            'h0100, 1,1};

        idle();
        rst_n = 1'b0;
        #3;
        chk("rst.busy",     32'(bus.busy),     32'h0);
        chk("rst.pend_cnt", 32'(bus.pend_cnt), 32'h0);
        chk("rst.wb_err",   32'(bus.wb_err),   32'h0);
        chk("rst.wr_en",    32'(bus.wr_en),    32'h0);
        chk("rst.hazard",   32'(bus.hazard),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) apply(i, tbl[i]);

        // Reset pulse while claims are pending and a write is registered.
        claim(4'd3);
        claim(4'd4);
        claim(4'd5);
        @(negedge clk);
        idle();
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd3; bus.alu_data = 32'h33;
        @(posedge clk);
        #1;
        chk("mid.wr_en", 32'(bus.wr_en), 32'h1);
        chk("mid.busy",  32'(bus.busy),  32'h0138);
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #1;
        chk("arst.busy",     32'(bus.busy),     32'h0);
        chk("arst.pend_cnt", 32'(bus.pend_cnt), 32'h0);
        chk("arst.wr_en",    32'(bus.wr_en),    32'h0);
        chk("arst.wr_addr",  32'(bus.wr_addr),  32'h0);
        chk("arst.wr_data",  bus.wr_data,       32'h0);
        chk("arst.wb_err",   32'(bus.wb_err),   32'h0);
        #1;
        rst_n = 1'b1;
        bus.iss_valid = 1'b1; bus.iss_dest = 4'd3;
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd2; bus.alu_data = 32'h22;
        bus.mem_valid = 1'b1; bus.mem_addr = 4'd6; bus.mem_data = 32'h66;
        #1;
        chk("post.iss_ready", 32'(bus.iss_ready), 32'h1);
        chk("post.alu_ready", 32'(bus.alu_ready), 32'h1);
        chk("post.mem_ready", 32'(bus.mem_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("post.busy",     32'(bus.busy),     32'h0008);
        chk("post.pend_cnt", 32'(bus.pend_cnt), 32'h1);
        chk("post.wr_en",    32'(bus.wr_en),    32'h1);
        chk("post.wr_addr",  32'(bus.wr_addr),  32'h2);
        chk("post.wr_data",  bus.wr_data,       32'h22);
        chk("post.wb_err",   32'(bus.wb_err),   32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
